bus_trace_ctrl: RTL and testbench

Controller for the 128-bit bus-trace RAM (ram_dual, one port owned by this block) inside the tile SFR space.
- Buffers captured host bus transactions in a small FIFO and writes them as timestamped entries into a circular trace buffer.
- Arbitrates the single RAM port between trace writes and host readback.
- Tracks count, wrap and overflow status.
- Sits between the sfr register decode (control, capture stream, readback) and the trace RAM.

---
 rtl/bus_trace_pkg.sv | 45 ++++
 rtl/bus_trace_ctrl_fifo.sv | 43 ++++
 rtl/bus_trace_ctrl.sv | 140 ++++++++++++++
 tb/tb_bus_trace_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_trace_pkg.sv
// Shared types and defaults for the bus-trace controller: entry layout,
// readback word selects and the readback sequencer states.
package bus_trace_pkg;

  localparam int DEPTH_POW_DEF = 10;
  localparam int FIFO_POW_DEF  = 2;
  localparam int DROP_W        = 16;

  localparam logic [1:0] WORD_DATA = 2'd0;
  localparam logic [1:0] WORD_ADDR = 2'd1;
  localparam logic [1:0] WORD_WE   = 2'd2;
  localparam logic [1:0] WORD_TS   = 2'd3;

  typedef struct packed {
    logic [31:0] ts;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_RESP
  } rd_state_t;

  // RAM line layout: {ts, 31'b0, we, addr, data}
  function automatic logic [127:0] entry_to_line(entry_t e);
    return {e.ts, 31'b0, e.we, e.addr, e.data};
  endfunction

  function automatic logic [31:0] select_word(logic [127:0] line, logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      WORD_DATA: w = line[31:0];
      WORD_ADDR: w = line[63:32];
      WORD_WE:   w = line[95:64];
      default:   w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bus_trace_ctrl_fifo.sv
// Small show-ahead synchronous FIFO for captured transactions; the head entry
// is visible on dout_bo so it can be written to the trace RAM in the pop cycle.
module trace_fifo #(
  parameter int WIDTH = 97,
  parameter int POW   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_bi,
  output logic [WIDTH-1:0] dout_bo,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_reg [2**POW];
  logic [POW:0]     wr_ptr_reg;
  logic [POW:0]     rd_ptr_reg;

  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[POW] != rd_ptr_reg[POW]) &&
                   (wr_ptr_reg[POW-1:0] == rd_ptr_reg[POW-1:0]);
  assign dout_bo = mem_reg[rd_ptr_reg[POW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_reg[wr_ptr_reg[POW-1:0]] <= din_bi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_i) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_i)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bus_trace_ctrl.sv
// Bus-trace RAM controller: timestamps captured bus transactions into a circular
// trace buffer and shares the single RAM port with a fixed-latency host readback.
module bus_trace_ctrl
  import bus_trace_pkg::*;
#(
  parameter int DEPTH_POW = DEPTH_POW_DEF,
  parameter int FIFO_POW  = FIFO_POW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 wrap_mode_i,
  input  logic                 clear_i,
  input  logic                 cap_valid_i,
  input  logic                 cap_we_i,
  input  logic [31:0]          cap_addr_bi,
  input  logic [31:0]          cap_data_bi,
  input  logic                 rd_req_i,
  input  logic [DEPTH_POW-1:0] rd_idx_bi,
  input  logic [1:0]           rd_word_bi,
  output logic                 rd_busy_o,
  output logic                 rd_resp_o,
  output logic [31:0]          rd_data_bo,
  output logic                 ram_we_o,
  output logic [DEPTH_POW-1:0] ram_addr_bo,
  output logic [127:0]         ram_wdata_bo,
  input  logic [127:0]         ram_rdata_bi,
  output logic [DEPTH_POW:0]   count_bo,
  output logic                 full_o,
  output logic                 wrapped_o,
  output logic [DROP_W-1:0]    drop_cnt_bo
);

  rd_state_t            rd_state_reg, rd_state_next;
  logic [31:0]          ts_reg;
  logic [DEPTH_POW-1:0] wr_ptr_reg;
  logic [DEPTH_POW-1:0] rd_addr_reg;
  logic [DEPTH_POW:0]   count_reg;
  logic                 wrapped_reg;
  logic [DROP_W-1:0]    drop_reg;
  logic [1:0]           rd_word_reg;
  logic                 rd_oob_reg;

  entry_t               fifo_din;
  entry_t               fifo_dout;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                 cap_ok, stop_full, rd_addr_phase, rd_accept;
  logic                 wr_en, drop_cap, drop_pop;
  logic [DEPTH_POW-1:0] oldest;
  logic [DROP_W:0]      drop_sum;

  // count never exceeds 2**DEPTH_POW, so its MSB alone means "full"
  assign rd_addr_phase = (rd_state_reg == RD_ADDR);
  assign rd_accept     = rd_req_i && !rd_addr_phase;
  assign stop_full     = !wrap_mode_i && count_reg[DEPTH_POW];
  assign cap_ok        = cap_valid_i && enable_i && !clear_i;
  assign fifo_push     = cap_ok && !fifo_full && !stop_full;
  assign drop_cap      = cap_ok && (fifo_full || stop_full);
  assign fifo_pop      = !rd_addr_phase && !fifo_empty && !clear_i;
  assign wr_en         = fifo_pop && !stop_full;
  assign drop_pop      = fifo_pop && stop_full;
  assign drop_sum      = {1'b0, drop_reg} + {{DROP_W{1'b0}}, drop_cap}
                                          + {{DROP_W{1'b0}}, drop_pop};
  assign oldest        = count_reg[DEPTH_POW] ? wr_ptr_reg : '0;
  assign fifo_din      = '{ts: ts_reg, we: cap_we_i, addr: cap_addr_bi, data: cap_data_bi};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .POW   (FIFO_POW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_bi  (fifo_din),
    .dout_bo (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (rd_req_i) rd_state_next = RD_ADDR;
      RD_ADDR: rd_state_next = RD_RESP;
      RD_RESP: rd_state_next = rd_req_i ? RD_ADDR : RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_reg <= RD_IDLE;
      rd_addr_reg  <= '0;
      rd_word_reg  <= '0;
      rd_oob_reg   <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_accept) begin
        rd_addr_reg <= oldest + rd_idx_bi;
        rd_word_reg <= rd_word_bi;
        rd_oob_reg  <= ({1'b0, rd_idx_bi} >= count_reg);
      end
    end
  end

  // clear wipes trace state but leaves an in-flight readback alone
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ts_reg      <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
      drop_reg    <= '0;
    end else begin
      ts_reg   <= ts_reg + 32'd1;
      drop_reg <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (count_reg[DEPTH_POW]) wrapped_reg <= 1'b1;
        else                      count_reg   <= count_reg + 1'b1;
      end
    end
  end

  assign ram_we_o     = wr_en;
  assign ram_addr_bo  = rd_addr_phase ? rd_addr_reg : wr_ptr_reg;
  assign ram_wdata_bo = entry_to_line(fifo_dout);

  assign rd_busy_o    = rd_addr_phase;
  assign rd_resp_o    = (rd_state_reg == RD_RESP);
  assign rd_data_bo   = (rd_resp_o && !rd_oob_reg) ? select_word(ram_rdata_bi, rd_word_reg) : '0;

  assign count_bo     = count_reg;
  assign full_o       = count_reg[DEPTH_POW];
  assign wrapped_o    = wrapped_reg;
  assign drop_cnt_bo  = drop_reg;

endmodule

// File: tb/tb_bus_trace_ctrl.sv
// Randomised bench for bus_trace_ctrl against a queue/array reference model,
// with a scoreboard monitor for readback address phases and responses.
module tb_bus_trace_ctrl;
  localparam int DP = 3;
  localparam int FP = 2;
  localparam int D  = 1 << DP;
  localparam int FD = 1 << FP;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0, wrap_mode_i = 1'b0, clear_i = 1'b0;
  logic          cap_valid_i = 1'b0, cap_we_i = 1'b0;
  logic [31:0]   cap_addr_bi = '0, cap_data_bi = '0;
  logic          rd_req_i = 1'b0;
  logic [DP-1:0] rd_idx_bi = '0;
  logic [1:0]    rd_word_bi = '0;
  logic          rd_busy_o, rd_resp_o, ram_we_o, full_o, wrapped_o;
  logic [31:0]   rd_data_bo;
  logic [DP-1:0] ram_addr_bo;
  logic [127:0]  ram_wdata_bo;
  logic [127:0]  ram_rdata_bi = '0;
  logic [DP:0]   count_bo;
  logic [15:0]   drop_cnt_bo;

  always #5 clk_i = ~clk_i;

  bus_trace_ctrl #(.DEPTH_POW(DP), .FIFO_POW(FP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .wrap_mode_i(wrap_mode_i),
    .clear_i(clear_i), .cap_valid_i(cap_valid_i), .cap_we_i(cap_we_i),
    .cap_addr_bi(cap_addr_bi), .cap_data_bi(cap_data_bi), .rd_req_i(rd_req_i),
    .rd_idx_bi(rd_idx_bi), .rd_word_bi(rd_word_bi), .rd_busy_o(rd_busy_o),
    .rd_resp_o(rd_resp_o), .rd_data_bo(rd_data_bo), .ram_we_o(ram_we_o),
    .ram_addr_bo(ram_addr_bo), .ram_wdata_bo(ram_wdata_bo), .ram_rdata_bi(ram_rdata_bi),
    .count_bo(count_bo), .full_o(full_o), .wrapped_o(wrapped_o), .drop_cnt_bo(drop_cnt_bo)
  );

  // Trace RAM port: read-first, data valid one cycle after the address
  logic [127:0] ram_mem [D];
  always @(posedge clk_i) begin
    if (ram_we_o) ram_mem[ram_addr_bo] <= ram_wdata_bo;
    ram_rdata_bi <= ram_mem[ram_addr_bo];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] ts;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ment_t;

  ment_t       mf[$];
  ment_t       mm[D];
  int          m_wr, m_count, m_drop;
  bit          m_wrapped, m_pend, m_oob;
  int          m_phys, m_word;
  logic [31:0] m_ts;

  logic [31:0] sb_data[$];
  int          sb_due[$];
  int          aq_addr[$];
  int          aq_due[$];

  bit en_sel = 1'b0, wrap_sel = 1'b0;

  function automatic logic [31:0] wsel(ment_t e, int w);
    case (w)
      0:       return e.data;
      1:       return e.addr;
      2:       return {31'b0, e.we};
      default: return e.ts;
    endcase
  endfunction

  task automatic model_init();
    mf.delete();
    m_wr = 0; m_count = 0; m_drop = 0; m_wrapped = 0; m_pend = 0; m_oob = 0;
    m_phys = 0; m_word = 0; m_ts = '0;
  endtask

  // One clock edge of behaviour, from current inputs and start-of-cycle state
  task automatic model_step();
    int    size0;
    int    cnt0;
    bit    pend0;
    bit    stopfull;
    int    inc;
    int    oldest;
    ment_t e;
    size0    = mf.size();
    cnt0     = m_count;
    pend0    = m_pend;
    stopfull = !wrap_mode_i && (cnt0 == D);
    inc      = 0;
    if (pend0) begin
      sb_data.push_back(m_oob ? 32'd0 : wsel(mm[m_phys], m_word));
      sb_due.push_back(cyc + 1);
    end
    if (rd_req_i && !pend0) begin
      oldest = (cnt0 == D) ? m_wr : 0;
      m_phys = (oldest + int'(rd_idx_bi)) % D;
      m_oob  = int'(rd_idx_bi) >= cnt0;
      m_word = int'(rd_word_bi);
      m_pend = 1;
      aq_addr.push_back(m_phys);
      aq_due.push_back(cyc + 1);
    end else begin
      m_pend = 0;
    end
    if (clear_i) begin
      mf.delete();
      m_wr = 0; m_count = 0; m_wrapped = 0; m_drop = 0; m_ts = '0;
      return;
    end
    if (!pend0 && size0 > 0) begin
      e = mf.pop_front();
      if (stopfull) inc++;
      else begin
        mm[m_wr] = e;
        m_wr = (m_wr + 1) % D;
        if (m_count == D) m_wrapped = 1;
        else m_count++;
      end
    end
    if (cap_valid_i && enable_i) begin
      if (size0 == FD || stopfull) inc++;
      else begin
        e.ts = m_ts; e.we = cap_we_i; e.addr = cap_addr_bi; e.data = cap_data_bi;
        mf.push_back(e);
      end
    end
    m_drop = (m_drop + inc > 65535) ? 65535 : m_drop + inc;
    m_ts   = m_ts + 32'd1;
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input bit cv, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input bit rq, input int idx, input int wd, input bit clr);
    @(negedge clk_i);
    chk("count", count_bo, m_count);
    chk("full", full_o, (m_count == D));
    chk("wrapped", wrapped_o, m_wrapped);
    chk("drop_cnt", drop_cnt_bo, m_drop);
    rst_i       = 1'b0;
    enable_i    = en_sel;
    wrap_mode_i = wrap_sel;
    cap_valid_i = cv;
    cap_we_i    = we;
    cap_addr_bi = a;
    cap_data_bi = d;
    rd_req_i    = rq;
    rd_idx_bi   = idx[DP-1:0];
    rd_word_bi  = wd[1:0];
    clear_i     = clr;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cap(input logic [31:0] a, input logic [31:0] d);
    drive(1, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input int idx, input int wd);
    drive(0, 0, 0, 0, 1, idx, wd, 0);
    idle(2);
  endtask

  // ---------------- monitor ----------------
  initial begin
    int          due;
    int          pa;
    logic [31:0] ed;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) continue;
      if (rd_busy_o) begin
        if (aq_addr.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rd_busy: unexpected busy at cycle %0d, expected idle", cyc);
        end else begin
          pa  = aq_addr.pop_front();
          due = aq_due.pop_front();
          chk("rd_addr_cycle", cyc, due);
          chk("rd_phys_addr", ram_addr_bo, pa);
          chk("ram_we_in_read", ram_we_o, 0);
        end
      end
      if (rd_resp_o) begin
        if (sb_data.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rd_resp: unexpected response %08h at cycle %0d", rd_data_bo, cyc);
        end else begin
          ed  = sb_data.pop_front();
          due = sb_due.pop_front();
          $display("readback @%0d: data=%08h expected=%08h", cyc, rd_data_bo, ed);
          chk("rd_resp_cycle", cyc, due);
          chk("rd_data", rd_data_bo, ed);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_rd_busy", rd_busy_o, 0);
    chk("rst_rd_resp", rd_resp_o, 0);
    chk("rst_rd_data", rd_data_bo, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_bo, 0);
    model_init();

    // three captures, in-range and out-of-range readback
    en_sel = 1; wrap_sel = 1;
    cap(32'h10, 1); cap(32'h14, 2); cap(32'h20, 3);
    idle(3);
    rd(1, 1); rd(1, 0); rd(1, 2); rd(2, 3); rd(5, 0);

    // clear coincident with a capture, then one fresh capture at physical 0
    drive(1, 1, 32'h99, 32'h99, 0, 0, 0, 1);
    idle(2);
    cap(32'h40, 32'hA5);
    idle(3);
    rd(0, 3); rd(0, 0); rd(1, 0);

    // wrap mode: 10 captures into 8 entries
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) cap(32'h100 + 4 * i, i);
    idle(4);
    rd(0, 0); rd(7, 0); rd(7, 3); rd(3, 1);

    // stop mode: 10 captures, excess dropped
    wrap_sel = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) cap(32'h200 + 4 * i, i);
    idle(4);
    rd(0, 0); rd(7, 0);

    // reads every other cycle during a capture burst
    wrap_sel = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 1, 32'h300 + 4 * i, 32'h50 + i, (i % 2) == 0, i % 3, 3, 0);
    idle(6);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, (i % 2) == 0, i / 2, 0, 0);
    idle(3);
    for (int i = 0; i < 6; i++) rd(i, 3);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) wrap_sel = 1'($urandom_range(0, 1));
      en_sel = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom_range(0, 9) < 3, $urandom_range(0, D - 1), $urandom_range(0, 3),
            $urandom_range(0, 499) == 0);
    end
    idle(6);

    chk("sb_drained", sb_data.size(), 0);
    chk("aq_drained", aq_addr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
